// File: rtl/branch_hazard_unit_pkg.sv
// Shared pipeline definitions for the branch hazard controller and the
// operand match logic: register index width, stall-need width and the
// stall FSM state encoding.
package branch_hazard_unit_pkg;

  localparam int REG_W  = 5;
  localparam int NEED_W = 2;

  // RUN evaluates hazards every cycle; HOLD plays out the remaining cycles
  // of a multi-cycle stall without looking at the hazard inputs.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [NEED_W-1:0] NEED_NONE = 2'd0;
  localparam logic [NEED_W-1:0] NEED_ONE  = 2'd1;
  localparam logic [NEED_W-1:0] NEED_TWO  = 2'd2;

endpackage

// File: rtl/branch_hazard_unit_hazard_match.sv
// hazard_match: combinational register-match terms for the ID stage
// against EX and MEM destinations, and the number of stall cycles the
// ID instruction needs before its operands can be forwarded.
module hazard_match #(
  parameter int REG_W = branch_hazard_unit_pkg::REG_W
) (
  input  logic [REG_W-1:0]                        rs1_ID,
  input  logic [REG_W-1:0]                        rs2_ID,
  input  logic                                    use_rs1_ID,
  input  logic                                    use_rs2_ID,
  input  logic                                    is_branch_ID,
  input  logic [REG_W-1:0]                        rd_EX,
  input  logic                                    reg_write_EX,
  input  logic                                    mem_read_EX,
  input  logic [REG_W-1:0]                        rd_MEM,
  input  logic                                    mem_read_MEM,
  output logic                                    m_ex,
  output logic                                    m_mem,
  output logic [branch_hazard_unit_pkg::NEED_W-1:0] need
);
  import branch_hazard_unit_pkg::*;

  logic m_ex1, m_ex2, m_mem1, m_mem2;

  // x0 is hardwired to zero, so a write to it can never be a dependency.
  assign m_ex1  = use_rs1_ID && (rd_EX  != '0) && (rd_EX  == rs1_ID);
  assign m_ex2  = use_rs2_ID && (rd_EX  != '0) && (rd_EX  == rs2_ID);
  assign m_mem1 = use_rs1_ID && (rd_MEM != '0) && (rd_MEM == rs1_ID);
  assign m_mem2 = use_rs2_ID && (rd_MEM != '0) && (rd_MEM == rs2_ID);
  assign m_ex   = m_ex1 || m_ex2;
  assign m_mem  = m_mem1 || m_mem2;

  // Classify the hazard: a branch on a load still in EX waits two cycles,
  // the other unforwardable cases wait one.
  always_comb begin
    need = NEED_NONE;
    if (is_branch_ID && mem_read_EX && m_ex) begin
      need = NEED_TWO;
    end else if ((is_branch_ID && reg_write_EX && !mem_read_EX && m_ex) ||
                 (is_branch_ID && mem_read_MEM && m_mem) ||
                 (!is_branch_ID && mem_read_EX && m_ex)) begin
      need = NEED_ONE;
    end
  end

endmodule

// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit: stall/flush controller for a 5-stage pipeline that
// resolves branches in ID. Holds PC and IF/ID and bubbles ID/EX while a
// branch or load-use operand cannot be forwarded, flushes IF/ID on a taken
// branch, and freezes everything while data memory is busy.
// Optional build macro HAZARD_PERF_CNT_EN adds stall and flush counters.
module branch_hazard_unit #(
  parameter int REG_W = branch_hazard_unit_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             is_branch_ID,
  input  logic             branch_taken_ID,
  input  logic [REG_W-1:0] rd_EX,
  input  logic             reg_write_EX,
  input  logic             mem_read_EX,
  input  logic [REG_W-1:0] rd_MEM,
  input  logic             mem_read_MEM,
  input  logic             mem_busy,
  output logic             stall_IF,
  output logic             bubble_EX,
  output logic             flush_IF,
  output logic             freeze,
  output logic [1:0]       stall_cnt
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flushes
`endif
);
  import branch_hazard_unit_pkg::*;

  state_t            state_q, state_d;
  logic [NEED_W-1:0] cnt_q, cnt_d;
  logic [NEED_W-1:0] need;
  logic              m_ex, m_mem;
  logic              stall_c, flush_c;

  hazard_match #(.REG_W(REG_W)) u_match (
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .use_rs1_ID   (use_rs1_ID),
    .use_rs2_ID   (use_rs2_ID),
    .is_branch_ID (is_branch_ID),
    .rd_EX        (rd_EX),
    .reg_write_EX (reg_write_EX),
    .mem_read_EX  (mem_read_EX),
    .rd_MEM       (rd_MEM),
    .mem_read_MEM (mem_read_MEM),
    .m_ex         (m_ex),
    .m_mem        (m_mem),
    .need         (need)
  );

  // Stall FSM state and remaining-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and same-cycle stall/flush decisions. A busy data memory
  // suspends the FSM entirely so a stall resumes where it left off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    flush_c = 1'b0;
    if (!mem_busy) begin
      unique case (state_q)
        RUN: begin
          // need is only ever nonzero alongside a register match.
          if ((m_ex || m_mem) && (need != NEED_NONE)) begin
            stall_c = 1'b1;
            cnt_d   = need - NEED_ONE;
            state_d = (need == NEED_TWO) ? HOLD : RUN;
          end else begin
            flush_c = is_branch_ID && branch_taken_ID;
          end
        end
        HOLD: begin
          stall_c = 1'b1;
          if (cnt_q <= NEED_ONE) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - NEED_ONE;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Reset silences every control output immediately, not at the next edge.
  assign stall_IF  = stall_c && !rst;
  assign bubble_EX = stall_c && !rst;
  assign flush_IF  = flush_c && !rst;
  assign freeze    = mem_busy && !rst;
  assign stall_cnt = cnt_q;

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters; stall/flush are already zero during a freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (stall_IF) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (flush_IF) perf_flushes      <= perf_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Bench for branch_hazard_unit: directed scenarios plus randomized traffic
// checked against a model that tracks the number of owed stall cycles.
module tb_branch_hazard_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
  logic             use_rs1_ID, use_rs2_ID, is_branch_ID, branch_taken_ID;
  logic             reg_write_EX, mem_read_EX, mem_read_MEM, mem_busy;
  logic             stall_IF, bubble_EX, flush_IF, freeze;
  logic [1:0]       stall_cnt;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_cycles, perf_flushes;
`endif

  logic [5:0] obs;
  assign obs = {stall_IF, bubble_EX, flush_IF, freeze, stall_cnt};

  int n_vec = 0;
  int n_err = 0;
  int owed = 0;                 // stall cycles still owed after this one
  int unsigned e_stalls = 0;
  int unsigned e_flushes = 0;

  branch_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .use_rs1_ID      (use_rs1_ID),
    .use_rs2_ID      (use_rs2_ID),
    .is_branch_ID    (is_branch_ID),
    .branch_taken_ID (branch_taken_ID),
    .rd_EX           (rd_EX),
    .reg_write_EX    (reg_write_EX),
    .mem_read_EX     (mem_read_EX),
    .rd_MEM          (rd_MEM),
    .mem_read_MEM    (mem_read_MEM),
    .mem_busy        (mem_busy),
    .stall_IF        (stall_IF),
    .bubble_EX       (bubble_EX),
    .flush_IF        (flush_IF),
    .freeze          (freeze),
    .stall_cnt       (stall_cnt)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // Stall cycles the current ID instruction requires, from the hazard rules.
  function automatic int ref_need();
    bit hit_ex, hit_mem;
    hit_ex  = (use_rs1_ID && rd_EX != 0 && rd_EX == rs1_ID) ||
              (use_rs2_ID && rd_EX != 0 && rd_EX == rs2_ID);
    hit_mem = (use_rs1_ID && rd_MEM != 0 && rd_MEM == rs1_ID) ||
              (use_rs2_ID && rd_MEM != 0 && rd_MEM == rs2_ID);
    if (is_branch_ID && mem_read_EX && hit_ex) return 2;
    if (is_branch_ID && reg_write_EX && !mem_read_EX && hit_ex) return 1;
    if (is_branch_ID && mem_read_MEM && hit_mem) return 1;
    if (!is_branch_ID && mem_read_EX && hit_ex) return 1;
    return 0;
  endfunction

  // Expected {stall, bubble, flush, freeze, stall_cnt} this cycle.
  function automatic logic [5:0] model_out();
    logic [1:0] c;
    c = 2'(owed);
    if (rst) return 6'b0;
    if (mem_busy) return {4'b0001, c};
    if (owed > 0) return {4'b1100, c};
    if (ref_need() > 0) return {4'b1100, c};
    return {2'b00, is_branch_ID && branch_taken_ID, 1'b0, c};
  endfunction

  task automatic idle();
    rs1_ID = '0; rs2_ID = '0; rd_EX = '0; rd_MEM = '0;
    use_rs1_ID = 0; use_rs2_ID = 0; is_branch_ID = 0; branch_taken_ID = 0;
    reg_write_EX = 0; mem_read_EX = 0; mem_read_MEM = 0; mem_busy = 0;
  endtask

  // Advance one clock: update the model from the current inputs, then
  // return at the following falling edge ready for new stimulus.
  task automatic tick();
    logic [5:0] e;
    int nxt;
    e = model_out();
    if (e[5]) e_stalls++;
    if (e[3]) e_flushes++;
    if (rst) nxt = 0;
    else if (mem_busy) nxt = owed;
    else if (owed > 0) nxt = owed - 1;
    else nxt = (ref_need() > 0) ? ref_need() - 1 : 0;
    @(posedge clk);
    owed = nxt;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    if (obs !== 6'b0) begin $display("FAIL reset_held: got %b want %b", obs, 6'b0); n_err++; end
    n_vec++;
    rst = 0;
    #1;
    if (obs !== 6'b0) begin $display("FAIL reset_release: got %b want %b", obs, 6'b0); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_load_branch();
    idle(); rd_EX = 5; reg_write_EX = 1; mem_read_EX = 1;
    is_branch_ID = 1; rs1_ID = 5; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b110000) begin $display("FAIL load_br_c1: got %b want %b", obs, 6'b110000); n_err++; end
    n_vec++;
    tick(); #1;
    if (obs !== 6'b110001) begin $display("FAIL load_br_c2: got %b want %b", obs, 6'b110001); n_err++; end
    n_vec++;
    tick();
    idle(); is_branch_ID = 1; rs1_ID = 5; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b000000) begin $display("FAIL load_br_c3: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_alu_branch();
    idle(); rd_EX = 7; reg_write_EX = 1; is_branch_ID = 1; rs2_ID = 7; use_rs2_ID = 1;
    #1;
    if (obs !== 6'b110000) begin $display("FAIL alu_br_c1: got %b want %b", obs, 6'b110000); n_err++; end
    n_vec++;
    tick();
    idle(); is_branch_ID = 1; rs2_ID = 7; use_rs2_ID = 1;
    #1;
    if (obs !== 6'b000000) begin $display("FAIL alu_br_c2: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    tick();
    idle(); rd_EX = 0; reg_write_EX = 1; mem_read_EX = 1; is_branch_ID = 1; rs2_ID = 0; use_rs2_ID = 1;
    #1;
    if (obs !== 6'b000000) begin $display("FAIL x0_no_stall: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_mem_load();
    idle(); rd_MEM = 3; mem_read_MEM = 1; is_branch_ID = 1; rs1_ID = 3; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b110000) begin $display("FAIL mem_ld_br: got %b want %b", obs, 6'b110000); n_err++; end
    n_vec++;
    tick();
    idle(); rd_EX = 3; reg_write_EX = 1; mem_read_EX = 1; rs1_ID = 3; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b110000) begin $display("FAIL load_use: got %b want %b", obs, 6'b110000); n_err++; end
    n_vec++;
    tick();
    idle(); rd_MEM = 3; mem_read_MEM = 1; rs1_ID = 3; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b000000) begin $display("FAIL mem_ld_nonbr: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_flush();
    idle(); is_branch_ID = 1; branch_taken_ID = 1; rs1_ID = 9; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b001000) begin $display("FAIL flush_taken: got %b want %b", obs, 6'b001000); n_err++; end
    n_vec++;
    tick();
    idle();
    #1;
    if (obs !== 6'b000000) begin $display("FAIL flush_after: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_flush_in_hold();
    idle(); rd_EX = 5; reg_write_EX = 1; mem_read_EX = 1;
    is_branch_ID = 1; branch_taken_ID = 1; rs1_ID = 5; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b110000) begin $display("FAIL hold_flush_c1: got %b want %b", obs, 6'b110000); n_err++; end
    n_vec++;
    tick();
    idle(); is_branch_ID = 1; branch_taken_ID = 1;   // hazard gone, still in HOLD
    #1;
    if (obs !== 6'b110001) begin $display("FAIL hold_flush_c2: got %b want %b", obs, 6'b110001); n_err++; end
    n_vec++;
    tick(); #1;
    if (obs !== 6'b001000) begin $display("FAIL hold_flush_c3: got %b want %b", obs, 6'b001000); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_freeze();
    idle(); rd_EX = 5; reg_write_EX = 1; mem_read_EX = 1; is_branch_ID = 1; rs1_ID = 5; use_rs1_ID = 1;
    #1;
    if (obs !== 6'b110000) begin $display("FAIL frz_c1: got %b want %b", obs, 6'b110000); n_err++; end
    n_vec++;
    tick();
    mem_busy = 1; is_branch_ID = 1; branch_taken_ID = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (obs !== 6'b000101) begin $display("FAIL frz_busy%0d: got %b want %b", i, obs, 6'b000101); n_err++; end
      n_vec++;
      tick();
    end
    mem_busy = 0;
    #1;
    if (obs !== 6'b110001) begin $display("FAIL frz_resume: got %b want %b", obs, 6'b110001); n_err++; end
    n_vec++;
    tick();
    idle();
    #1;
    if (obs !== 6'b000000) begin $display("FAIL frz_done: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    idle(); rd_EX = 6; reg_write_EX = 1; mem_read_EX = 1; is_branch_ID = 1; rs2_ID = 6; use_rs2_ID = 1;
    tick(); #1;
    if (obs !== 6'b110001) begin $display("FAIL rst_pre_hold: got %b want %b", obs, 6'b110001); n_err++; end
    n_vec++;
    #1 rst = 1;
    #1;
    if (obs !== 6'b000000) begin $display("FAIL rst_async: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    owed = 0; e_stalls = 0; e_flushes = 0;
    @(posedge clk); @(negedge clk);
    rst = 0; idle();
    #1;
    if (obs !== 6'b000000) begin $display("FAIL rst_after: got %b want %b", obs, 6'b000000); n_err++; end
    n_vec++;
    tick();
  endtask

  task automatic test_random();
    logic [5:0] e;
    for (int i = 0; i < 400; i++) begin
      rs1_ID = REG_W'($urandom_range(0, 3));
      rs2_ID = REG_W'($urandom_range(0, 3));
      rd_EX = REG_W'($urandom_range(0, 3));
      rd_MEM = REG_W'($urandom_range(0, 3));
      use_rs1_ID = 1'($urandom_range(0, 1));
      use_rs2_ID = 1'($urandom_range(0, 1));
      is_branch_ID = 1'($urandom_range(0, 1));
      branch_taken_ID = 1'($urandom_range(0, 1));
      reg_write_EX = 1'($urandom_range(0, 1));
      mem_read_EX = 1'($urandom_range(0, 1));
      mem_read_MEM = 1'($urandom_range(0, 1));
      mem_busy = ($urandom_range(0, 7) == 0);
      #1;
      e = model_out();
      if (obs !== e) begin $display("FAIL random[%0d]: got %b want %b", i, obs, e); n_err++; end
      n_vec++;
      if (stall_IF && flush_IF) begin $display("FAIL stall_flush_excl[%0d]: got both=1 want not both", i); n_err++; end
      n_vec++;
      tick();
    end
    idle();
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_CNT_EN
    if (perf_stall_cycles !== CNT_W'(e_stalls)) begin
      $display("FAIL perf_stalls: got %0d want %0d", perf_stall_cycles, e_stalls); n_err++;
    end
    n_vec++;
    if (perf_flushes !== CNT_W'(e_flushes)) begin
      $display("FAIL perf_flushes: got %0d want %0d", perf_flushes, e_flushes); n_err++;
    end
    n_vec++;
`endif
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_branch();
    test_alu_branch();
    test_mem_load();
    test_flush();
    test_flush_in_hold();
    test_freeze();
    test_reset_mid_hold();
    test_random();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_hazard_unit.md
Name: branch_hazard_unit

Overview:
- Stall/flush controller for the 5-stage pipeline with branches resolved in ID.
- Branch-operand forwarding supplies values from EX and MEM. This block covers the cases forwarding cannot serve:
  - an operand still being computed in EX;
  - an operand still being loaded in EX or MEM.
- It holds PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on a taken branch.
- A registered stall FSM sequences multi-cycle stalls and honours a data-memory busy freeze.

Parameters:
REG_W, 5, register index width
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous active-high reset
rs1_ID  input  REG_W  source register 1 of the instruction in ID
rs2_ID  input  REG_W  source register 2 of the instruction in ID
use_rs1_ID  input  1  ID instruction reads rs1
use_rs2_ID  input  1  ID instruction reads rs2
is_branch_ID  input  1  ID instruction is a conditional branch or jalr
branch_taken_ID  input  1  branch in ID resolved taken (valid only when is_branch_ID)
rd_EX  input  REG_W  destination register in EX
reg_write_EX  input  1  EX instruction writes rd
mem_read_EX  input  1  EX instruction is a load
rd_MEM  input  REG_W  destination register in MEM
mem_read_MEM  input  1  MEM instruction is a load
mem_busy  input  1  data memory not ready; the whole pipeline must freeze
stall_IF  output  1  hold PC and IF/ID
bubble_EX  output  1  load NOP into ID/EX
flush_IF  output  1  clear IF/ID (taken branch)
freeze  output  1  hold every pipeline register (mirrors mem_busy)
stall_cnt  output  2  remaining registered stall cycles (debug)

Behaviour:
- Match terms:
  - mEX1 = use_rs1_ID & rd_EX!=0 & rd_EX==rs1_ID; mEX2 likewise for rs2. mEX = mEX1|mEX2.
  - mMEM = same construction against rd_MEM.
- Hazard classes, evaluated only in state RUN; need = 0/1/2:
  - need=2: is_branch_ID & mem_read_EX & mEX.
  - need=1, any of:
    - is_branch_ID & reg_write_EX & !mem_read_EX & mEX;
    - is_branch_ID & mem_read_MEM & mMEM;
    - !is_branch_ID & mem_read_EX & mEX.
  - need=0 otherwise.
- States RUN and HOLD; stall_cnt register. Reset: state=RUN, stall_cnt=0.
- RUN:
  - need>0: stall_IF=1, bubble_EX=1 this cycle. On the edge: stall_cnt=need-1; go to HOLD if need==2, else stay in RUN.
  - need==0: no stall.
- HOLD:
  - stall_IF=1, bubble_EX=1; hazard inputs are ignored.
  - Edge: stall_cnt decrements; on reaching 0, return to RUN.
  - RUN then re-evaluates; the forwarded value is now available.
- flush_IF = is_branch_ID & branch_taken_ID & state==RUN & need==0 & !mem_busy.
  - A branch resolved while stalled is never acted upon.
- Freeze:
  - freeze = mem_busy, combinational.
  - While mem_busy=1: state and stall_cnt hold; stall_IF, bubble_EX and flush_IF are forced to 0.
  - The stall resumes exactly where it was after mem_busy deasserts.
- Stall and flush are never asserted together.
- Reset asserted mid-HOLD: immediate return to RUN/cnt=0; all outputs 0 while rst=1.
- stall_IF, bubble_EX and flush_IF are combinational from inputs and state: zero-latency, same-cycle response.
- An rd of x0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds two outputs:
  - perf_stall_cycles (CNT_W): increments each cycle stall_IF=1.
  - perf_flushes (CNT_W): increments each cycle flush_IF=1.
  - Both reset to 0 and wrap modulo 2^CNT_W.
  - Neither increments while freeze=1.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package:
  - REG_W constant;
  - state encoding (RUN=1'b0, HOLD=1'b1);
  - localparam NEED_W=2.
- Sub-module hazard_match: combinational computation of mEX/mMEM and need, reusable by the ALU-path forwarding logic.
- FSM and counters remain in the top module.

Test Plan:
- Load EX rd=5, branch in ID rs1=5 -> stall_IF/bubble_EX=1 for 2 cycles (stall_cnt 1 then 0), RUN on cycle 3.
- ALU EX rd=7 writes, branch rs2=7 -> exactly 1 stall cycle. Repeat with rd=0 -> no stall.
- Load in MEM rd=3, branch rs1=3 -> 1 stall. Non-branch add with rs1=3 against a load in EX rd=3 -> 1 stall. Against a load in MEM only -> no stall.
- Branch taken, no hazard -> flush_IF=1 for one cycle, stall_IF=0. Taken branch during HOLD -> flush_IF=0 until RUN.
- 2-cycle stall, mem_busy=1 for 3 cycles after the first stall cycle -> freeze=1, stall outputs 0, stall_cnt held at 1. After release, 1 more stall cycle.
- rst pulse during HOLD -> outputs 0 asynchronously, stall_cnt=0. With HAZARD_PERF_CNT_EN: after the above, perf counters match the counted stall/flush cycles.
